// File: rtl/pixie_arb_pkg.sv
// Shared types and constants for the Pixie memory arbiter.
package pixie_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    SRC_VID = 1'b0,
    SRC_CPU = 1'b1
  } arb_src_e;

  // Consecutive video grants tolerated while the CPU waits (guard build only).
  localparam int unsigned STARVE_LIMIT = 8;
  localparam int unsigned STARVE_CNT_W = 4;
  // Wide enough for RAM_LAT-1 with RAM_LAT up to 3.
  localparam int unsigned LAT_CNT_W    = 2;

endpackage

// File: rtl/pixie_mem_arbiter.sv
// Single-port RAM arbiter between the Pixie DMA fetch port and the CDP1802 bus.
// Video has strict priority unless built with PIXIE_ARB_STARVE_GUARD_EN, which
// forces a CPU grant after STARVE_LIMIT video grants made while the CPU waits.
module pixie_mem_arbiter
  import pixie_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              vid_req,
  output logic              vid_ack,
  output logic [7:0]        vid_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  if ((RAM_LAT == 0) || (RAM_LAT > 3)) begin : g_bad_ram_lat
    $error("pixie_mem_arbiter: RAM_LAT must be in 1..3");
  end

  arb_state_e            r_state, w_state_nxt;
  arb_src_e              r_src, w_src_nxt;
  logic [ADDR_W-1:0]     r_addr, w_addr_nxt;
  logic [7:0]            r_wdata, w_wdata_nxt;
  logic                  r_we, w_we_nxt;
  logic [LAT_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic                  r_mem_en, w_mem_en_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic                  r_vid_ack, w_vid_ack_nxt;
  logic                  r_cpu_ack, w_cpu_ack_nxt;
  logic [7:0]            r_vid_data, w_vid_data_nxt;
  logic [7:0]            r_cpu_rdata, w_cpu_rdata_nxt;

  logic                  w_cpu_req;
  logic                  w_force_cpu;
  logic                  w_grant_vid;
  logic                  w_grant_cpu;

  assign w_cpu_req = cpu_rd | cpu_wr;

`ifdef PIXIE_ARB_STARVE_GUARD_EN
  logic [STARVE_CNT_W-1:0] r_starve_cnt;

  assign w_force_cpu = w_cpu_req && (r_starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));

  // Count video grants that overtook a waiting CPU; reset once the CPU is served or gone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (!w_cpu_req || w_grant_cpu) begin
        r_starve_cnt <= '0;
      end else if (w_grant_vid) begin
        r_starve_cnt <= r_starve_cnt + STARVE_CNT_W'(1);
      end
    end
  end
`else
  assign w_force_cpu = 1'b0;
`endif

  assign w_grant_vid = (r_state == IDLE) && vid_req && !w_force_cpu;
  assign w_grant_cpu = (r_state == IDLE) && w_cpu_req && !w_grant_vid;

  // Next-state and next-output decode for the access sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_src_nxt       = r_src;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_we_nxt        = r_we;
    w_cnt_nxt       = r_cnt;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_vid_ack_nxt   = 1'b0;
    w_cpu_ack_nxt   = 1'b0;
    w_vid_data_nxt  = r_vid_data;
    w_cpu_rdata_nxt = r_cpu_rdata;

    unique case (r_state)
      IDLE: begin
        if (w_grant_vid) begin
          w_state_nxt  = ISSUE;
          w_src_nxt    = SRC_VID;
          w_addr_nxt   = vid_addr;
          w_we_nxt     = 1'b0;
          w_mem_en_nxt = 1'b1;
        end else if (w_grant_cpu) begin
          // A simultaneous rd+wr is illegal; the write wins.
          w_state_nxt  = ISSUE;
          w_src_nxt    = SRC_CPU;
          w_addr_nxt   = cpu_addr;
          w_wdata_nxt  = cpu_wdata;
          w_we_nxt     = cpu_wr;
          w_mem_en_nxt = 1'b1;
          w_mem_we_nxt = cpu_wr;
        end
      end
      ISSUE: begin
        if (r_we) begin
          w_state_nxt   = DONE;
          w_cpu_ack_nxt = 1'b1;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = LAT_CNT_W'(RAM_LAT - 1);
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
          if (r_src == SRC_VID) begin
            w_vid_data_nxt = mem_rdata;
            w_vid_ack_nxt  = 1'b1;
          end else begin
            w_cpu_rdata_nxt = mem_rdata;
            w_cpu_ack_nxt   = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - LAT_CNT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_src       <= SRC_VID;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_vid_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_vid_data  <= '0;
      r_cpu_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_src       <= w_src_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_we        <= w_we_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_vid_ack   <= w_vid_ack_nxt;
      r_cpu_ack   <= w_cpu_ack_nxt;
      r_vid_data  <= w_vid_data_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
    end
  end

  assign vid_ack   = r_vid_ack;
  assign vid_data  = r_vid_data;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_wait  = w_cpu_req & ~r_cpu_ack;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  // The CPU must never read and write in the same cycle.
  a_cpu_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset) !(cpu_rd && cpu_wr));

endmodule
